// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: memory size codes, fault causes and
// the load/store unit state encoding.
package rv32_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [1:0] FC_MISALIGN = 2'b00;
  localparam logic [1:0] FC_BUSERR   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLSIZE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic size_legal(input logic [2:0] s);
    return (s == SZ_B) || (s == SZ_H) || (s == SZ_W) ||
           (s == SZ_BU) || (s == SZ_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] s,
                                      input logic [1:0] a);
    return (s[1:0] == 2'b01 && a[0]) ||
           (s[1:0] == 2'b10 && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import rv32_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (size_i)
      SZ_B:    data_o = {{24{b[7]}}, b};
      SZ_BU:   data_o = {24'd0, b};
      SZ_H:    data_o = {{16{h[15]}}, h};
      SZ_HU:   data_o = {16'd0, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs EX/MEM memory requests over a
// req/ack data bus, stalls while busy, returns extended load data.
module mem_lsu
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  mem_size_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        stall_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [4:0]  rda_q, rda_d;
  logic        wen_q, wen_d;
  logic [31:0] ldata_q, ldata_d;
  logic        req_q, req_d;

  logic        req;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_ext;

  load_align u_align (
    .addr_i  (addr_q[1:0]),
    .size_i  (size_q),
    .rdata_i (ldata_q),
    .data_o  (ld_ext)
  );

  assign req = mem_we_i | mem_re_i;

  // Lane placement of the incoming request
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = mem_data_i;
    if (mem_we_i) begin
      unique case (mem_size_i[1:0])
        2'b00: begin
          be_n    = 4'b0001 << mem_addr_i[1:0];
          wdata_n = {4{mem_data_i[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << mem_addr_i[1:0];
          wdata_n = {2{mem_data_i[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = mem_data_i;
        end
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    size_d        = size_q;
    rda_d         = rda_q;
    wen_d         = wen_q;
    ldata_d       = ldata_q;
    req_d         = req_q;
    rd_addr_o     = rd_addr_i;
    rd_data_o     = rd_data_i;
    rd_wen_o      = rd_wen_i;
    stall_o       = 1'b0;
    fault_o       = 1'b0;
    fault_cause_o = FC_MISALIGN;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          rd_wen_o = 1'b0;
          if (!size_legal(mem_size_i)) begin
            fault_o       = 1'b1;
            fault_cause_o = FC_ILLSIZE;
          end else if (misaligned(mem_size_i, mem_addr_i[1:0])) begin
            fault_o       = 1'b1;
            fault_cause_o = FC_MISALIGN;
          end else begin
            stall_o = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
            addr_d  = mem_addr_i;
            wdata_d = wdata_n;
            be_d    = be_n;
            we_d    = mem_we_i;
            size_d  = mem_size_i;
            rda_d   = rd_addr_i;
            wen_d   = rd_wen_i;
            req_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        stall_o  = 1'b1;
        rd_wen_o = 1'b0;
        cnt_d    = cnt_q + 8'd1;
        if (bus_err_i) begin
          stall_o       = 1'b0;
          fault_o       = 1'b1;
          fault_cause_o = FC_BUSERR;
          state_d       = ST_IDLE;
          req_d         = 1'b0;
        end else if (bus_ack_i) begin
          if (!we_q) ldata_d = bus_rdata_i;
          state_d = ST_RESP;
          req_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          stall_o       = 1'b0;
          fault_o       = 1'b1;
          fault_cause_o = FC_TIMEOUT;
          state_d       = ST_IDLE;
          req_d         = 1'b0;
        end
      end
      ST_RESP: begin
        rd_addr_o = rda_q;
        rd_data_o = ld_ext;
        rd_wen_o  = wen_q & ~we_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      rd_wen_o      = 1'b0;
      stall_o       = 1'b0;
      fault_o       = 1'b0;
      fault_cause_o = FC_MISALIGN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_W;
      rda_q   <= 5'd0;
      wen_q   <= 1'b0;
      ldata_q <= 32'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      size_q  <= size_d;
      rda_q   <= rda_d;
      wen_q   <= wen_d;
      ldata_q <= ldata_d;
      req_q   <= req_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;

endmodule
